clken_divider_seq: RTL and testbench
====================================

Name: clken_divider_seq

Overview:
- Parametrised successor to the fixed-ratio PLL clock wrapper.
- Runs entirely on one PLL output clock and derives CHANNELS independent, runtime-programmable, phase-offset clock-enable strobes, replacing extra PLL outputs.
- Sequences system reset from PLL lock: synchronise, wait for lock stability, hold reset, then run.
- Detects loss of lock.

Parameters:
- CHANNELS, 4: number of clock-enable channels (1..16).
- DIV_WIDTH, 8: width of divisor and phase fields.
- LOCK_STABLE, 1024: cycles the synchronised lock must stay high before reset hold begins (>=1).
- RST_HOLD, 16: cycles sys_reset stays asserted after lock is stable (>=1).
- DEFAULT_DIV, 2: divisor loaded into every channel on reset.

Ports:
- clock, in, 1: PLL output clock; sole clock domain.
- reset, in, 1: synchronous, active-high.
- pll_locked, in, 1: PLL LOCK; asynchronous to clock.
- cfg_we, in, 1: one-cycle write strobe for channel config.
- cfg_sel, in, max(1,clog2(CHANNELS)): target channel; values >= CHANNELS are ignored.
- cfg_div, in, DIV_WIDTH: new divisor.
- cfg_phase, in, DIV_WIDTH: new phase offset.
- cfg_pending, out, CHANNELS: bit n high while a write to channel n awaits application.
- sys_reset, out, 1: downstream synchronous reset, active-high.
- clk_en, out, CHANNELS: one-cycle enable strobes.
- running, out, 1: high in RUN.
- lock_lost, out, 1: sticky; lock dropped while in RUN.

Behaviour:
- Reset values:
  - sys_reset=1, clk_en=0, running=0, lock_lost=0, cfg_pending=0.
  - Every channel: div=DEFAULT_DIV, phase=0, counter=0.
  - FSM=WAIT_LOCK; synchroniser flops=0.
- All outputs are registered.
- pll_locked passes through a 2-flop synchroniser; lock_s is the synchronised signal.
- FSM:
  - WAIT_LOCK: sys_reset=1, clk_en=0. Goes to STABLE when lock_s=1; stable counter cleared.
  - STABLE: counter increments each cycle. lock_s=0 returns to WAIT_LOCK. When counter reaches LOCK_STABLE-1, goes to HOLD.
  - HOLD: sys_reset=1 for exactly RST_HOLD cycles. Each channel counter is loaded with its effective phase. lock_s=0 returns to WAIT_LOCK. Then goes to RUN.
  - RUN: sys_reset=0, running=1. lock_s=0 goes to WAIT_LOCK on the next edge, sets lock_lost=1, and forces clk_en=0 and sys_reset=1 on that same edge.
- Timing: pll_locked held high from sampling edge k gives first RUN cycle (running=1, sys_reset=0) after edge k+2+LOCK_STABLE+RST_HOLD.
- Divider, per channel, in RUN only:
  - Effective divisor d = max(div,1).
  - If counter==0: clk_en[n]=1 and counter<=d-1. Otherwise clk_en[n]=0 and counter decrements.
  - d=1 gives clk_en held high continuously.
- Effective phase = min(phase, d-1). The first strobe occurs in RUN cycle (effective phase), 0-based.
- Config writes:
  - cfg_we latches cfg_div and cfg_phase into channel shadow registers and sets cfg_pending[n] on the next edge.
  - A second write before application overwrites the shadow (last write wins).
  - Outside RUN: the shadow is applied on the edge after the write, and cfg_pending clears then.
  - In RUN: the shadow is applied on the edge of a strobe cycle (counter==0). The counter is reloaded with new d-1 and phase is ignored (realignment only happens through HOLD). cfg_pending clears on the same edge.
  - The current period always completes, so no runt or double strobes occur.
  - A write on the same cycle as application of an older shadow keeps pending set and the newer values.
- Reset asserted mid-operation returns everything to reset values on the next edge. lock_lost clears only by reset.

Test Plan:
- Power-up, LOCK_STABLE=8, RST_HOLD=4: pll_locked rises at edge 10 -> sys_reset falls and running rises after edge 24; clk_en[0] with div=2, phase=0 strobes in RUN cycles 0,2,4.
- Channel 1 written pre-RUN with div=3, phase=1 -> strobes at RUN cycles 1,4,7. Write div=0 -> clk_en[1] continuously high.
- In RUN, write channel 0 div=5 two cycles after a strobe -> one more strobe at the old period, then a period of 5. cfg_pending[0] is high exactly from the write+1 edge to the applying edge.
- pll_locked glitches low for 1 cycle midway through STABLE -> FSM returns to WAIT_LOCK and the full LOCK_STABLE+RST_HOLD is re-counted. lock_lost stays 0.
- pll_locked drops in RUN -> within 3 edges clk_en=0, sys_reset=1, running=0, lock_lost=1. On relock the sequence repeats and lock_lost stays 1 until reset.
- Reset asserted mid-RUN with pending writes -> next cycle all outputs are at reset values and divisors revert to DEFAULT_DIV.

Source files
------------

// File: rtl/clken_divider_seq.sv
// clken_divider_seq
//   Single-clock sequencer and clock-enable generator. The PLL lock signal is
//   synchronised, has to stay stable for LOCK_STABLE cycles, and sys_reset is
//   then held for RST_HOLD more cycles before the block enters RUN. In RUN,
//   CHANNELS independent dividers produce one-cycle clk_en strobes. Each
//   channel's divisor and phase can be changed at runtime.
// Ports
//   clock        : PLL output clock, the only clock
//   reset        : synchronous, active-high
//   pll_locked   : raw PLL lock, asynchronous to clock
//   cfg_we       : one-cycle write strobe for channel config
//   cfg_sel      : target channel (values >= CHANNELS are ignored)
//   cfg_div      : new divisor (0 behaves as 1)
//   cfg_phase    : new phase offset (clamped to divisor-1)
//   cfg_pending  : bit n set while a write to channel n waits to be applied
//   sys_reset    : downstream synchronous reset, active-high
//   clk_en       : per-channel one-cycle enable strobes
//   running      : high in RUN
//   lock_lost    : sticky, lock dropped while in RUN (cleared only by reset)
module clken_divider_seq #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_STABLE = 1024,
  parameter int RST_HOLD    = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pll_locked,
  input  logic                 cfg_we,
  input  logic [SEL_W-1:0]     cfg_sel,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [DIV_WIDTH-1:0] cfg_phase,
  output logic [CHANNELS-1:0]  cfg_pending,
  output logic                 sys_reset,
  output logic [CHANNELS-1:0]  clk_en,
  output logic                 running,
  output logic                 lock_lost
);

  localparam int CNT_MAX = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Divisor 0 is treated as 1.
  function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] div);
    return (div == DIV_WIDTH'(0)) ? DIV_WIDTH'(1) : div;
  endfunction

  // Phase is clamped so the first strobe always lands inside the first period.
  function automatic logic [DIV_WIDTH-1:0] eff_phase(input logic [DIV_WIDTH-1:0] phase,
                                                     input logic [DIV_WIDTH-1:0] div);
    logic [DIV_WIDTH-1:0] dm1;
    dm1 = eff_div(div) - DIV_WIDTH'(1);
    return (phase > dm1) ? dm1 : phase;
  endfunction

  logic                 sync1_q, sync2_q;
  logic                 lock_s;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sys_reset_q, running_q, lock_lost_q, lock_lost_d;
  logic [CHANNELS-1:0]  pend_q, pend_d, clk_en_q, clk_en_d;
  logic [DIV_WIDTH-1:0] div_q [CHANNELS];
  logic [DIV_WIDTH-1:0] div_d [CHANNELS];
  logic [DIV_WIDTH-1:0] phase_q [CHANNELS];
  logic [DIV_WIDTH-1:0] phase_d [CHANNELS];
  logic [DIV_WIDTH-1:0] sh_div_q [CHANNELS];
  logic [DIV_WIDTH-1:0] sh_div_d [CHANNELS];
  logic [DIV_WIDTH-1:0] sh_phase_q [CHANNELS];
  logic [DIV_WIDTH-1:0] sh_phase_d [CHANNELS];
  logic [DIV_WIDTH-1:0] ctr_q [CHANNELS];
  logic [DIV_WIDTH-1:0] ctr_d [CHANNELS];

  assign lock_s = sync2_q;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Lock sequencing FSM next state; cnt_q is shared by STABLE and HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = CNT_W'(0);
        end else begin
          cnt_d   = CNT_W'(0);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(0);
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(0);
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = CNT_W'(0);
      end
    endcase
  end

  // Per-channel config shadowing, application and divider next state.
  // ctr_q holds the counter value for the current cycle, so clk_en_d is
  // decoded from ctr_d and the strobe output stays a plain register.
  always_comb begin
    lock_lost_d = lock_lost_q | ((state_q == ST_RUN) & ~lock_s);
    pend_d      = pend_q;
    clk_en_d    = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      logic wr;
      logic apply;
      wr    = cfg_we && (cfg_sel == SEL_W'(n));
      // Outside RUN apply at once; in RUN only at the end of a strobe cycle
      // so the running period always completes.
      apply = pend_q[n] && ((state_q != ST_RUN) || (ctr_q[n] == DIV_WIDTH'(0)));

      div_d[n]      = apply ? sh_div_q[n]   : div_q[n];
      phase_d[n]    = apply ? sh_phase_q[n] : phase_q[n];
      sh_div_d[n]   = wr ? cfg_div   : sh_div_q[n];
      sh_phase_d[n] = wr ? cfg_phase : sh_phase_q[n];

      if (wr) begin
        pend_d[n] = 1'b1;
      end else if (apply) begin
        pend_d[n] = 1'b0;
      end else begin
        pend_d[n] = pend_q[n];
      end

      if (state_q == ST_RUN) begin
        if (ctr_q[n] == DIV_WIDTH'(0)) begin
          ctr_d[n] = eff_div(div_d[n]) - DIV_WIDTH'(1);
        end else begin
          ctr_d[n] = ctr_q[n] - DIV_WIDTH'(1);
        end
      end else begin
        // Preload the phase so RUN cycle 0 starts at the effective phase.
        ctr_d[n] = eff_phase(phase_d[n], div_d[n]);
      end

      clk_en_d[n] = (state_d == ST_RUN) && (ctr_d[n] == DIV_WIDTH'(0));
    end
  end

  // State, channel and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= CNT_W'(0);
      sys_reset_q <= 1'b1;
      running_q   <= 1'b0;
      lock_lost_q <= 1'b0;
      pend_q      <= '0;
      clk_en_q    <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        div_q[n]      <= DIV_WIDTH'(DEFAULT_DIV);
        phase_q[n]    <= DIV_WIDTH'(0);
        sh_div_q[n]   <= DIV_WIDTH'(DEFAULT_DIV);
        sh_phase_q[n] <= DIV_WIDTH'(0);
        ctr_q[n]      <= DIV_WIDTH'(0);
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_reset_q <= (state_d != ST_RUN);
      running_q   <= (state_d == ST_RUN);
      lock_lost_q <= lock_lost_d;
      pend_q      <= pend_d;
      clk_en_q    <= clk_en_d;
      for (int n = 0; n < CHANNELS; n++) begin
        div_q[n]      <= div_d[n];
        phase_q[n]    <= phase_d[n];
        sh_div_q[n]   <= sh_div_d[n];
        sh_phase_q[n] <= sh_phase_d[n];
        ctr_q[n]      <= ctr_d[n];
      end
    end
  end

  assign cfg_pending = pend_q;
  assign sys_reset   = sys_reset_q;
  assign clk_en      = clk_en_q;
  assign running     = running_q;
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_clken_divider_seq.sv
// Testbench for clken_divider_seq with LOCK_STABLE=8, RST_HOLD=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_clken_divider_seq;

  localparam int CH = 4;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          pll_locked;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [DW-1:0] cfg_div;
  logic [DW-1:0] cfg_phase;
  logic [CH-1:0] cfg_pending;
  logic          sys_reset;
  logic [CH-1:0] clk_en;
  logic          running;
  logic          lock_lost;

  int total = 0;
  int bad   = 0;
  logic [CH-1:0] exp_en_q[$];
  logic [CH-1:0] exp_pend_q[$];

  clken_divider_seq #(
    .CHANNELS(CH), .DIV_WIDTH(DW), .LOCK_STABLE(8), .RST_HOLD(4), .DEFAULT_DIV(2)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .cfg_pending(cfg_pending), .sys_reset(sys_reset), .clk_en(clk_en),
    .running(running), .lock_lost(lock_lost)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b0; cfg_we = 1'b0;
    cfg_sel = 2'd0; cfg_div = 8'd0; cfg_phase = 8'd0;
    repeat (3) tick();
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL reset_sys_reset got=%b want=1", sys_reset); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
    total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL reset_lock_lost got=%b want=0", lock_lost); end
    total++; if (clk_en !== 4'b0000) begin bad++; $display("FAIL reset_clk_en got=%b want=0000", clk_en); end
    total++; if (cfg_pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b want=0000", cfg_pending); end
    reset = 1'b0;
    tick();
  endtask

  // Channel 1: div 3 phase 1; channel 2: div 0 (continuous enable).
  task automatic test_config_pre_run();
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_div = 8'd3; cfg_phase = 8'd1;
    tick();
    cfg_we = 1'b0;
    total++; if (cfg_pending !== 4'b0010) begin bad++; $display("FAIL pre_run_pending_set got=%b want=0010", cfg_pending); end
    tick();
    total++; if (cfg_pending !== 4'b0000) begin bad++; $display("FAIL pre_run_pending_clear got=%b want=0000", cfg_pending); end
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_div = 8'd0; cfg_phase = 8'd0;
    tick();
    cfg_we = 1'b0;
    tick();
  endtask

  // Channel 3: write div 9, then div 2 in the very next cycle; the newer one must survive.
  task automatic test_back_to_back();
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_div = 8'd9; cfg_phase = 8'd0;
    tick();
    cfg_div = 8'd2;
    tick();
    cfg_we = 1'b0;
    total++; if (cfg_pending !== 4'b1000) begin bad++; $display("FAIL b2b_pending_kept got=%b want=1000", cfg_pending); end
    tick();
    total++; if (cfg_pending !== 4'b0000) begin bad++; $display("FAIL b2b_pending_clear got=%b want=0000", cfg_pending); end
  endtask

  // Lock sampled at edge k; first RUN cycle follows edge k+14.
  task automatic test_power_up();
    pll_locked = 1'b1;
    repeat (14) tick();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL pu_running_early got=%b want=0", running); end
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL pu_sys_reset_early got=%b want=1", sys_reset); end
    tick();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL pu_running got=%b want=1", running); end
    total++; if (sys_reset !== 1'b0) begin bad++; $display("FAIL pu_sys_reset got=%b want=0", sys_reset); end
  endtask

  // RUN cycles 0..35. Channel 0 is rewritten to div 5 in cycle 14.
  task automatic test_divider();
    for (int c = 0; c < 36; c++) begin
      logic [CH-1:0] e;
      e[0] = (c <= 16) ? (c % 2 == 0) : ((c >= 21) && ((c - 21) % 5 == 0));
      e[1] = (c % 3 == 1);
      e[2] = 1'b1;
      e[3] = (c % 2 == 0);
      exp_en_q.push_back(e);
      exp_pend_q.push_back(((c == 15) || (c == 16)) ? 4'b0001 : 4'b0000);
    end
    for (int c = 0; c < 36; c++) begin
      logic [CH-1:0] e_en;
      logic [CH-1:0] e_pd;
      if (c == 14) begin
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_div = 8'd5; cfg_phase = 8'd0;
      end else begin
        cfg_we = 1'b0;
      end
      e_en = exp_en_q.pop_front();
      e_pd = exp_pend_q.pop_front();
      total++; if (clk_en !== e_en) begin bad++; $display("FAIL div_clk_en cycle=%0d got=%b want=%b", c, clk_en, e_en); end
      total++; if (cfg_pending !== e_pd) begin bad++; $display("FAIL div_pending cycle=%0d got=%b want=%b", c, cfg_pending, e_pd); end
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    repeat (2) tick();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL loss_running_early got=%b want=1", running); end
    tick();
    total++; if (clk_en !== 4'b0000) begin bad++; $display("FAIL loss_clk_en got=%b want=0000", clk_en); end
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL loss_sys_reset got=%b want=1", sys_reset); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL loss_running got=%b want=0", running); end
    total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL loss_lock_lost got=%b want=1", lock_lost); end
  endtask

  // Relock: ch0 div5 ph0, ch1 div3 ph1, ch2 d=1, ch3 div2 ph0 -> RUN cycle 0 = 1101.
  task automatic test_relock();
    pll_locked = 1'b1;
    repeat (14) tick();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL relock_running_early got=%b want=0", running); end
    tick();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL relock_running got=%b want=1", running); end
    total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL relock_lock_lost got=%b want=1", lock_lost); end
    total++; if (clk_en !== 4'b1101) begin bad++; $display("FAIL relock_clk_en got=%b want=1101", clk_en); end
  endtask

  task automatic test_reset_mid_run();
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_div = 8'd7; cfg_phase = 8'd0;
    tick();
    cfg_we = 1'b0;
    total++; if (cfg_pending !== 4'b1000) begin bad++; $display("FAIL mid_pending got=%b want=1000", cfg_pending); end
    reset = 1'b1; pll_locked = 1'b0;
    tick();
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL mid_sys_reset got=%b want=1", sys_reset); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL mid_running got=%b want=0", running); end
    total++; if (clk_en !== 4'b0000) begin bad++; $display("FAIL mid_clk_en got=%b want=0000", clk_en); end
    total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL mid_lock_lost got=%b want=0", lock_lost); end
    total++; if (cfg_pending !== 4'b0000) begin bad++; $display("FAIL mid_pending_clear got=%b want=0000", cfg_pending); end
    reset = 1'b0;
    tick();
  endtask

  // Lock sampled high at k, low at k+6, high again from k+7: RUN follows edge k+21.
  // All channels must be back at the default divisor.
  task automatic test_glitch();
    pll_locked = 1'b1;
    repeat (6) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (8) tick();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL glitch_no_early_run got=%b want=0", running); end
    repeat (6) tick();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL glitch_running_early got=%b want=0", running); end
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL glitch_sys_reset_early got=%b want=1", sys_reset); end
    tick();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL glitch_running got=%b want=1", running); end
    total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL glitch_lock_lost got=%b want=0", lock_lost); end
    for (int c = 0; c < 6; c++) exp_en_q.push_back((c % 2 == 0) ? 4'b1111 : 4'b0000);
    for (int c = 0; c < 6; c++) begin
      logic [CH-1:0] e_en;
      e_en = exp_en_q.pop_front();
      total++; if (clk_en !== e_en) begin bad++; $display("FAIL default_div cycle=%0d got=%b want=%b", c, clk_en, e_en); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_config_pre_run();
    test_back_to_back();
    test_power_up();
    test_divider();
    test_lock_loss();
    test_relock();
    test_reset_mid_run();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
